// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with blanking, PWM brightness and frame snapshot.
// Optional SEG_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int N_DIG       = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 4,
  parameter int COM_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [4*N_DIG-1:0] DIN,
  input  logic [N_DIG-1:0]   DP,
  input  logic [N_DIG-1:0]   EN,
  input  logic [3:0]         BRIGHT,
  output logic [N_DIG-1:0]   SEG_COM,
  output logic [7:0]         SEG_DATA,
  output logic               FRAME_TICK
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [N_DIG-1:0] COM_OFF = (COM_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic               run_q, run_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] din_q, din_d;
  logic [N_DIG-1:0]   dp_q, dp_d;
  logic [N_DIG-1:0]   en_q, en_d;
  logic [3:0]         br_q, br_d;
  logic [N_DIG-1:0]   com_q, com_d;
  logic [7:0]         data_q, data_d;
  logic               tick_q, tick_d;

  logic               take;
  logic [N_DIG-1:0]   sup;
  logic [N_DIG-1:0]   sel;
  logic [3:0]         nib;
  logic               dp_b;
  logic               on_b;
  logic [3:0]         phase;
  logic               lit;
`ifdef SEG_LZ_BLANK_EN
  logic               lz;
`endif

  always_comb begin
    run_d = 1'b1;
    pos_d = pos_q;
    idx_d = idx_q;
    take  = 1'b0;
    if (!run_q) begin
      pos_d = '0;
      idx_d = '0;
      take  = 1'b1;
    end else if (pos_q == PW'(SCAN_DIV - 1)) begin
      pos_d = '0;
      if (idx_q == IW'(N_DIG - 1)) begin
        idx_d = '0;
        take  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pos_d = pos_q + PW'(1);
    end

    din_d = take ? DIN : din_q;
    dp_d  = take ? DP : dp_q;
    en_d  = take ? EN : en_q;
    br_d  = take ? BRIGHT : br_q;

    // Outputs are computed from next-state so the register shows slot position p.
    sup = '0;
`ifdef SEG_LZ_BLANK_EN
    lz = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      lz     = lz & (din_d[4*i +: 4] == 4'h0) & ~dp_d[i];
      sup[i] = lz;
    end
`endif

    sel  = '0;
    nib  = '0;
    dp_b = 1'b0;
    on_b = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_d == IW'(i)) begin
        sel[i] = 1'b1;
        nib    = din_d[4*i +: 4];
        dp_b   = dp_d[i];
        on_b   = en_d[i] & ~sup[i];
      end
    end

    phase  = 4'(32'(pos_d) - 32'(BLANK_CYC));
    lit    = on_b && (32'(pos_d) >= 32'(BLANK_CYC)) && (phase <= br_d);
    com_d  = (lit ? sel : '0) ^ COM_OFF;
    data_d = {dp_b, hex7(nib)} ^ SEG_OFF;
    tick_d = (pos_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q  <= 1'b0;
      pos_q  <= '0;
      idx_q  <= '0;
      din_q  <= '0;
      dp_q   <= '0;
      en_q   <= '0;
      br_q   <= '0;
      com_q  <= COM_OFF;
      data_q <= SEG_OFF;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      pos_q  <= pos_d;
      idx_q  <= idx_d;
      din_q  <= din_d;
      dp_q   <= dp_d;
      en_q   <= en_d;
      br_q   <= br_d;
      com_q  <= com_d;
      data_q <= data_d;
      tick_q <= tick_d;
    end
  end

  assign SEG_COM    = com_q;
  assign SEG_DATA   = data_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: N_DIG=4, SCAN_DIV=40, BLANK_CYC=4.
// Slot-level scans check activity count, pattern, glyph and frame tick.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [3:0]  bright;
  logic [3:0]  com;
  logic [7:0]  dat;
  logic        tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .N_DIG(4), .SCAN_DIV(40), .BLANK_CYC(4),
    .COM_ACT_LOW(1), .SEG_ACT_LOW(0)
  ) dut (
    .CLK(clk), .RST(rst), .DIN(din), .DP(dp), .EN(en),
    .BRIGHT(bright), .SEG_COM(com), .SEG_DATA(dat),
    .FRAME_TICK(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input string tag, input int e_act,
                      input logic [3:0] e_pat, input logic [7:0] e_dat,
                      input int e_tick);
    int act, first, ticks, badpat, baddat;
    logic [7:0] d0;
    act = 0; first = -1; ticks = 0; badpat = 0; baddat = 0;
    d0 = dat;
    for (int p = 0; p < 40; p++) begin
      if (com !== 4'hF) begin
        act++;
        if (first < 0) first = p;
        if (com !== e_pat) badpat++;
      end
      if (dat !== e_dat) baddat++;
      if (tick === 1'b1) ticks++;
      if (tick === 1'b1 && p != 0) ticks += 100;
      step();
    end
    chk({tag, ".act"}, act, e_act);
    chk({tag, ".data"}, d0, e_dat);
    chk({tag, ".data_stable"}, baddat, 0);
    chk({tag, ".tick"}, ticks, e_tick);
    if (e_act > 0) begin
      chk({tag, ".pattern"}, badpat, 0);
      chk({tag, ".first_on"}, first, 4);
    end
  endtask

  initial begin
    rst = 1'b1; din = 16'h1234; dp = 4'h0; en = 4'hF; bright = 4'd15;
    step();
    step();
    chk("rst.com", com, 4'hF);
    chk("rst.data", dat, 8'h00);
    chk("rst.tick", tick, 1'b0);
    @(negedge clk) rst = 1'b0;
    step();

    // frame 1: 1234 full brightness; DIN changes during slot 1
    scan("f1s0", 36, 4'b1110, 8'h66, 1);
    din = 16'hABCD;
    scan("f1s1", 36, 4'b1101, 8'h4F, 0);
    scan("f1s2", 36, 4'b1011, 8'h5B, 0);
    scan("f1s3", 36, 4'b0111, 8'h06, 0);

    // frame 2: new snapshot ABCD; brightness drop lands next frame
    scan("f2s0", 36, 4'b1110, 8'h5E, 1);
    bright = 4'd0;
    scan("f2s1", 36, 4'b1101, 8'h39, 0);
    scan("f2s2", 36, 4'b1011, 8'h7C, 0);
    scan("f2s3", 36, 4'b0111, 8'h77, 0);

    // frame 3: BRIGHT=0 -> p=4,20,36 only
    scan("f3s0", 3, 4'b1110, 8'h5E, 1);
    bright = 4'd7;
    scan("f3s1", 3, 4'b1101, 8'h39, 0);
    scan("f3s2", 3, 4'b1011, 8'h7C, 0);
    scan("f3s3", 3, 4'b0111, 8'h77, 0);

    // frame 4: BRIGHT=7 -> 20 active cycles
    scan("f4s0", 20, 4'b1110, 8'h5E, 1);
    din = 16'h1234; en = 4'b1011; dp = 4'b0001; bright = 4'd15;
    scan("f4s1", 20, 4'b1101, 8'h39, 0);
    scan("f4s2", 20, 4'b1011, 8'h7C, 0);
    scan("f4s3", 20, 4'b0111, 8'h77, 0);

    // frame 5: digit 2 disabled, DP on digit 0
    scan("f5s0", 36, 4'b1110, 8'hE6, 1);
    scan("f5s1", 36, 4'b1101, 8'h4F, 0);
    scan("f5s2", 0, 4'b1011, 8'h5B, 0);
    din = 16'h0050; dp = 4'h0; en = 4'hF;
    scan("f5s3", 36, 4'b0111, 8'h06, 0);

    // frame 6: leading zeros
    scan("f6s0", 36, 4'b1110, 8'h3F, 1);
    scan("f6s1", 36, 4'b1101, 8'h6D, 0);
`ifdef SEG_LZ_BLANK_EN
    scan("f6s2", 0, 4'b1011, 8'h3F, 0);
    scan("f6s3", 0, 4'b0111, 8'h3F, 0);
`else
    scan("f6s2", 36, 4'b1011, 8'h3F, 0);
    scan("f6s3", 36, 4'b0111, 8'h3F, 0);
`endif

    // frame 7: reset at slot 2 p=17
    din = 16'h9876;
    scan("f7s0", 36, 4'b1110, 8'h3F, 1);
    scan("f7s1", 36, 4'b1101, 8'h6D, 0);
    for (int k = 0; k < 17; k++) step();
    chk("pre_rst.com", com, 4'b1011);
    rst = 1'b1;
    #1;
    chk("arst.com", com, 4'hF);
    chk("arst.data", dat, 8'h00);
    chk("arst.tick", tick, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold.com", com, 4'hF);
    end
    @(negedge clk) rst = 1'b0;
    step();
    scan("r_s0", 36, 4'b1110, 8'h7D, 1);
    scan("r_s1", 36, 4'b1101, 8'h07, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
